keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x4 matrix keypad, debounces the press and emits a 4-bit key code
//   with a single-cycle push strobe. It feeds the digit-collection stage
//   (entrada/push inputs of the 4-digit shift register). Exactly one push is
//   produced per physical press, regardless of bounce or hold time.
// PARAMETERS
//   SCAN_DIV        default 4      clk cycles each column is driven; must be >= 4
//   DEBOUNCE_CYCLES default 8      consecutive stable cycles needed for press/release
// PORTS
//   clk      in   1  system clock
//   rst      in   1  reset, asynchronous, active-low (0 = reset)
//   fila     in   4  keypad rows, active-low, pulled up, asynchronous to clk
//   columna  out  4  keypad column drive, active-low, one-hot-zero
//   entrada  out  4  code of the last accepted key; held until the next push
//   push     out  1  1-cycle strobe, asserted in the same cycle entrada updates
//   tecla    out  1  high while a key is accepted and not yet released
// BEHAVIOUR
// - Reset (rst=0, async): columna=4'b1110, entrada=0, push=0, tecla=0,
//   state=SCAN, all counters 0, synchroniser flops = 4'hF.
// - fila passes through a 2-FF synchroniser (fila_s); the FSM sees only fila_s.
// - Key code: row r, column c -> r0:1,2,3,A  r1:4,5,6,B  r2:7,8,9,C  r3:E(*),0,F(#),D.
// - FSM:
//   SCAN: div counter 0..SCAN_DIV-1; sample fila_s only at count SCAN_DIV-1
//     (covers the 2-cycle sync latency). Sample==4'hF -> rotate columna left
//     (1110->1101->1011->0111->1110), wrap-around. Exactly one fila_s bit low ->
//     latch row/col, columna frozen, deb=0, go DEBOUNCE. More than one bit low
//     -> treated as no key, keep scanning.
//   DEBOUNCE: fila_s equals latched pattern -> deb++; any mismatch -> back to
//     SCAN (resume rotation from the frozen column, no push). When deb reaches
//     DEBOUNCE_CYCLES-1 with a match: next cycle push=1, entrada=code, tecla=1,
//     go PRESSED.
//   PRESSED: columna held. fila_s==4'hF -> deb=0, go RELEASE. Otherwise stay
//     (no further push, however long the hold).
//   RELEASE: fila_s==4'hF -> deb++; any low bit -> back to PRESSED (no push).
//     deb reaches DEBOUNCE_CYCLES-1 -> tecla=0, go SCAN and resume rotation.
// - push high for exactly one cycle per accepted press; never in two consecutive
//   cycles. entrada changes only together with push.
// - A second key pressed while one is held produces no push.
// - Reset mid-operation: immediate return to reset values. A key still held
//   after reset release is accepted again as a new press (one push).
// - Counters sized $clog2 of their parameter; no overflow possible (bounded
//   by the comparisons above).
// STRUCTURE
// - keypad_pkg: state enum (SCAN, DEBOUNCE, PRESSED, RELEASE), code LUT
//   function key_code(row_idx, col_idx) -> logic [3:0], COL_RESET constant.
// - Sub-module sync_2ff (parameter W=4, reset value all ones) for fila.
// - Top: FSM, scan divider, debounce counter, output registers.
// TESTING (SCAN_DIV=4, DEBOUNCE_CYCLES=8, clk 10 ns)
// 1 Reset, no key -> columna=1110, push=0, entrada=0; columna steps
//   1110,1101,1011,0111,1110 every 4 clk.
// 2 Hold row1 low while col2 driven ('6'), 200 clk -> exactly one push,
//   entrada=4'h6, tecla=1, columna stays 1011; release -> tecla=0 after
//   8 stable clk, scanning resumes.
// 3 Row0/col3 bouncing (toggle every 3 clk for 30 clk, then stable) -> single
//   push, entrada=4'hA; release bounce -> no extra push.
// 4 Glitch: row2 low for 5 clk only -> no push, scanning resumes.
// 5 Row0 and row3 low together -> no push; '*' alone -> 4'hE, '#' alone -> 4'hF.
// 6 rst=0 asserted while in PRESSED -> outputs at reset values same cycle; key
//   still held after rst=1 -> one new push with the same code.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, key code
// table and one-hot-zero decoding of row/column patterns.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Keypad legend, row-major: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    code = 4'h0;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic single_low(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  // Position of the single zero bit; only meaningful when single_low() holds.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to all ones so that
// idle pulled-up keypad rows read as "no key" straight out of reset.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg <= '1;
      sync_reg <= '1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates the column drive, debounces press and
// release, and emits one key code with a single-cycle push per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fila,
  output logic [3:0] columna,
  output logic [3:0] entrada,
  output logic       push,
  output logic       tecla
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    fila_s;
  state_t        state_reg;
  logic [DW-1:0] div_reg;
  logic [BW-1:0] deb_reg;
  logic [3:0]    col_reg;
  logic [3:0]    pattern_reg;
  logic [3:0]    entrada_reg;
  logic          push_reg;
  logic          tecla_reg;

  sync_2ff #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (fila),
    .q   (fila_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= SCAN;
      div_reg     <= '0;
      deb_reg     <= '0;
      col_reg     <= COL_RESET;
      pattern_reg <= 4'hF;
      entrada_reg <= 4'h0;
      push_reg    <= 1'b0;
      tecla_reg   <= 1'b0;
    end else begin
      push_reg <= 1'b0;
      case (state_reg)
        SCAN: begin
          // Sampling late in the slot lets the new column settle through the synchroniser.
          if (div_reg == DIV_LAST) begin
            div_reg <= '0;
            if (single_low(fila_s)) begin
              pattern_reg <= fila_s;
              deb_reg     <= '0;
              state_reg   <= DEBOUNCE;
            end else begin
              col_reg <= {col_reg[2:0], col_reg[3]};
            end
          end else begin
            div_reg <= div_reg + DW'(1);
          end
        end
        DEBOUNCE: begin
          if (fila_s == pattern_reg) begin
            if (deb_reg == DEB_LAST) begin
              push_reg    <= 1'b1;
              entrada_reg <= key_code(low_index(pattern_reg), low_index(col_reg));
              tecla_reg   <= 1'b1;
              state_reg   <= PRESSED;
            end else begin
              deb_reg <= deb_reg + BW'(1);
            end
          end else begin
            div_reg   <= '0;
            state_reg <= SCAN;
          end
        end
        PRESSED: begin
          if (fila_s == 4'hF) begin
            deb_reg   <= '0;
            state_reg <= RELEASE;
          end
        end
        RELEASE: begin
          // Any bounce back to a low row restarts the release wait without a new push.
          if (fila_s != 4'hF) begin
            state_reg <= PRESSED;
          end else if (deb_reg == DEB_LAST) begin
            tecla_reg <= 1'b0;
            div_reg   <= '0;
            state_reg <= SCAN;
          end else begin
            deb_reg <= deb_reg + BW'(1);
          end
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

  assign columna = col_reg;
  assign entrada = entrada_reg;
  assign push    = push_reg;
  assign tecla   = tecla_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: a physical keypad model drives the rows from the key
// matrix and the column drive; pushes are collected and compared per press.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] fila;
  logic [3:0] columna;
  logic [3:0] entrada;
  logic       push;
  logic       tecla;

  logic [15:0] key_down  = '0;
  logic [3:0]  force_low = '0;
  logic [3:0]  code_tab [16];
  logic [3:0]  code_q [$];
  logic        prev_push = 1'b0;
  logic [3:0]  prev_entrada = 4'h0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst     (rst),
    .fila    (fila),
    .columna (columna),
    .entrada (entrada),
    .push    (push),
    .tecla   (tecla)
  );

  // A row reads low when a pressed key in it sits on the driven column.
  always_comb begin
    fila = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !columna[c]) fila[r] = 1'b0;
    fila = fila & ~force_low;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (push) begin
        chk("push_one_cycle", 32'(prev_push), 32'd0);
        code_q.push_back(entrada);
      end
      if (entrada !== prev_entrada) chk("entrada_only_with_push", 32'(push), 32'd1);
    end
    prev_push    <= push;
    prev_entrada <= entrada;
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] col_mask(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic txn_press(input int r, input int c, input bit bounce);
    int k;
    int p;
    k = r * 4 + c;
    p = $urandom_range(1, 3);
    code_q.delete();
    if (bounce)
      for (int t = 0; t < 30; t++) begin
        key_down[k] = ((t / p) % 2) == 0;
        @(negedge clk);
      end
    key_down[k] = 1'b1;
    ticks($urandom_range(60, 200));
    chk("push_count_hold", 32'(code_q.size()), 32'd1);
    chk("entrada_code", 32'(entrada), 32'(code_tab[k]));
    chk("tecla_held", 32'(tecla), 32'd1);
    chk("columna_frozen", 32'(columna), 32'(col_mask(c)));
    if (bounce)
      for (int t = 0; t < 20; t++) begin
        key_down[k] = ((t / p) % 2) == 1;
        @(negedge clk);
      end
    key_down[k] = 1'b0;
    ticks(40);
    chk("push_count_release", 32'(code_q.size()), 32'd1);
    chk("tecla_released", 32'(tecla), 32'd0);
    $display("[TB] press r%0d c%0d bounce=%0d pushes=%0d entrada=%0h", r, c, bounce, code_q.size(), entrada);
  endtask

  task automatic txn_glitch(input int r, input int len);
    logic [3:0] col_a;
    code_q.delete();
    force_low[r] = 1'b1;
    ticks(len);
    force_low = '0;
    ticks(40);
    chk("glitch_no_push", 32'(code_q.size()), 32'd0);
    chk("glitch_tecla", 32'(tecla), 32'd0);
    col_a = columna;
    ticks(SCAN_DIV);
    chk("scan_resumes", 32'(col_a != columna), 32'd1);
    $display("[TB] glitch row%0d len=%0d pushes=%0d", r, len, code_q.size());
  endtask

  task automatic txn_multi(input logic [15:0] keys, input logic [3:0] frc);
    code_q.delete();
    key_down  = keys;
    force_low = frc;
    ticks(100);
    chk("multi_no_push", 32'(code_q.size()), 32'd0);
    chk("multi_tecla", 32'(tecla), 32'd0);
    key_down  = '0;
    force_low = '0;
    ticks(40);
    $display("[TB] multi keys=%04h force=%0h pushes=%0d", keys, frc, code_q.size());
  endtask

  initial begin
    int mode, r, c, r2;
    logic [15:0] keys;
    code_tab = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    ticks(3);
    chk("reset_columna", 32'(columna), 32'hE);
    chk("reset_push", 32'(push), 32'd0);
    chk("reset_entrada", 32'(entrada), 32'd0);
    chk("reset_tecla", 32'(tecla), 32'd0);
    #2 rst = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1 chk("scan_step", 32'(columna), 32'(col_mask((n / SCAN_DIV) % 4)));
    end
    $display("[TB] scan rotation checked over 20 cycles");
    ticks(2);

    txn_press(1, 2, 1'b0);
    txn_press(0, 3, 1'b1);
    txn_glitch(2, 5);
    txn_multi(16'h0, 4'b1001);
    txn_press(3, 0, 1'b0);
    txn_press(3, 2, 1'b0);

    // Reset while a key is held, then the same key must be accepted once more.
    code_q.delete();
    key_down[6] = 1'b1;
    ticks(80);
    chk("pre_reset_push", 32'(code_q.size()), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midreset_columna", 32'(columna), 32'hE);
    chk("midreset_push", 32'(push), 32'd0);
    chk("midreset_entrada", 32'(entrada), 32'd0);
    chk("midreset_tecla", 32'(tecla), 32'd0);
    ticks(3);
    code_q.delete();
    #2 rst = 1'b1;
    ticks(80);
    chk("post_reset_push", 32'(code_q.size()), 32'd1);
    chk("post_reset_entrada", 32'(entrada), 32'h6);
    chk("post_reset_tecla", 32'(tecla), 32'd1);
    key_down = '0;
    ticks(40);
    chk("post_reset_release", 32'(tecla), 32'd0);
    $display("[TB] reset during hold: pushes after reset=%0d entrada=%0h", code_q.size(), entrada);

    for (int i = 0; i < 20; i++) begin
      mode = $urandom_range(0, 3);
      r    = $urandom_range(0, 3);
      c    = $urandom_range(0, 3);
      case (mode)
        0: txn_press(r, c, 1'b0);
        1: txn_press(r, c, 1'b1);
        2: txn_glitch(r, $urandom_range(1, 6));
        default: begin
          r2   = (r + 1 + $urandom_range(0, 2)) % 4;
          keys = '0;
          keys[r*4+c]  = 1'b1;
          keys[r2*4+c] = 1'b1;
          txn_multi(keys, 4'h0);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
